sg_peak_detect: RTL and testbench

- Downstream consumer of the Savitzky-Golay smoothing stage.
- Takes the smoothed sample stream (one sample per in_valid strobe) and finds local maxima that rise above a programmable threshold and then fall by a programmable hysteresis.
- For each peak it reports the value and the sample index, with a minimum-spacing rule.
- Output feeds the capture/readout logic.

---
 rtl/sg_peak_detect.sv | 154 +++++++++++++++
 tb/tb_sg_peak_detect.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sg_peak_detect.sv
// Peak detector for the smoothed sample stream: finds local maxima above a threshold
// that are confirmed by a hysteresis fall, and enforces a minimum spacing between reports.
module sg_peak_detect #(
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 16,
    parameter int MIN_DIST = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] hysteresis,
    output logic              peak_valid,
    output logic [DATA_W-1:0] peak_value,
    output logic [IDX_W-1:0]  peak_index,
    output logic [CNT_W-1:0]  peak_count,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BELOW, TRACK, FALL} state_t;

    state_t                    state, stateNext;
    logic signed [DATA_W-1:0]  thrReg, thrNext;
    logic        [DATA_W-1:0]  hystReg, hystNext;
    logic        [IDX_W-1:0]   idx, idxNext;
    logic signed [DATA_W-1:0]  cand, candNext;
    logic        [IDX_W-1:0]   candIdx, candIdxNext;
    logic signed [DATA_W-1:0]  minVal, minValNext;
    logic        [IDX_W-1:0]   lastIdx, lastIdxNext;
    logic                      noPrev, noPrevNext;
    logic                      peakValidNext;
    logic        [DATA_W-1:0]  peakValueNext;
    logic        [IDX_W-1:0]   peakIndexNext;
    logic        [CNT_W-1:0]   peakCountNext;

    logic signed [DATA_W-1:0]  sample;
    logic signed [DATA_W:0]    fallDiff, riseDiff, hystExt;
    logic        [IDX_W-1:0]   gap;
    logic                      reportOk;

    // Differences are one bit wider than the data so extreme swings never wrap.
    assign sample   = data_in;
    assign fallDiff = {cand[DATA_W-1], cand} - {sample[DATA_W-1], sample};
    assign riseDiff = {sample[DATA_W-1], sample} - {minVal[DATA_W-1], minVal};
    assign hystExt  = {1'b0, hystReg};
    assign gap      = candIdx - lastIdx;
    assign reportOk = noPrev || (gap >= IDX_W'(MIN_DIST));
    assign busy     = (state != IDLE);

    always_comb begin
        stateNext     = state;
        thrNext       = thrReg;
        hystNext      = hystReg;
        idxNext       = idx;
        candNext      = cand;
        candIdxNext   = candIdx;
        minValNext    = minVal;
        lastIdxNext   = lastIdx;
        noPrevNext    = noPrev;
        peakValidNext = 1'b0;
        peakValueNext = peak_value;
        peakIndexNext = peak_index;
        peakCountNext = peak_count;

        if (start) begin
            stateNext     = BELOW;
            thrNext       = threshold;
            hystNext      = hysteresis;
            idxNext       = '0;
            noPrevNext    = 1'b1;
            peakCountNext = '0;
        end else if (in_valid && state != IDLE) begin
            idxNext = idx + 1'b1;
            case (state)
                BELOW: begin
                    if (sample >= thrReg) begin
                        candNext    = sample;
                        candIdxNext = idx;
                        stateNext   = TRACK;
                    end
                end
                TRACK: begin
                    if (sample > cand) begin
                        candNext    = sample;
                        candIdxNext = idx;
                    end else if (fallDiff >= hystExt) begin
                        minValNext = sample;
                        stateNext  = (sample >= thrReg) ? FALL : BELOW;
                        // Too-close peaks still move the FSM on, they are just not reported.
                        if (reportOk) begin
                            peakValidNext = 1'b1;
                            peakValueNext = cand;
                            peakIndexNext = candIdx;
                            lastIdxNext   = candIdx;
                            noPrevNext    = 1'b0;
                            if (peak_count != '1)
                                peakCountNext = peak_count + 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (sample < thrReg) begin
                        stateNext = BELOW;
                    end else if (sample < minVal) begin
                        minValNext = sample;
                    end else if (riseDiff >= hystExt) begin
                        candNext    = sample;
                        candIdxNext = idx;
                        stateNext   = TRACK;
                    end
                end
                default: stateNext = IDLE;
            endcase
            if (idx == '1)
                stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            thrReg     <= '0;
            hystReg    <= '0;
            idx        <= '0;
            cand       <= '0;
            candIdx    <= '0;
            minVal     <= '0;
            lastIdx    <= '0;
            noPrev     <= 1'b1;
            peak_valid <= 1'b0;
            peak_value <= '0;
            peak_index <= '0;
            peak_count <= '0;
        end else begin
            state      <= stateNext;
            thrReg     <= thrNext;
            hystReg    <= hystNext;
            idx        <= idxNext;
            cand       <= candNext;
            candIdx    <= candIdxNext;
            minVal     <= minValNext;
            lastIdx    <= lastIdxNext;
            noPrev     <= noPrevNext;
            peak_valid <= peakValidNext;
            peak_value <= peakValueNext;
            peak_index <= peakIndexNext;
            peak_count <= peakCountNext;
        end
    end

endmodule

// File: tb/tb_sg_peak_detect.sv
// Directed bench for sg_peak_detect: hand-computed peak reports for short sample frames.
module tb_sg_peak_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] threshold = '0;
    logic [15:0] hysteresis = '0;
    logic        peak_valid;
    logic [15:0] peak_value;
    logic [15:0] peak_index;
    logic [7:0]  peak_count;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;
    logic [15:0] vec[$];
    logic [31:0] pvBits;
    int pvSeen;

    sg_peak_detect #(.DATA_W(16), .IDX_W(16), .MIN_DIST(8), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .data_in(data_in),
        .threshold(threshold),
        .hysteresis(hysteresis),
        .peak_valid(peak_valid),
        .peak_value(peak_value),
        .peak_index(peak_index),
        .peak_count(peak_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic doStart(input logic [15:0] thr, input logic [15:0] hyst);
        threshold  = thr;
        hysteresis = hyst;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Drives vec back-to-back; bit k of pvBits is peak_valid seen right after sample k.
    task automatic applyStimulus();
        pvBits = '0;
        foreach (vec[k]) begin
            in_valid = 1'b1;
            data_in  = vec[k];
            @(posedge clk); #1;
            if (k < 32) pvBits[k] = peak_valid;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state and samples ignored without start
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_pv", {31'd0, peak_valid}, 0);
        checkOutput("reset_value", {16'd0, peak_value}, 0);
        checkOutput("reset_index", {16'd0, peak_index}, 0);
        checkOutput("reset_count", {24'd0, peak_count}, 0);
        checkOutput("reset_busy", {31'd0, busy}, 0);
        pvSeen = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = 16'($urandom);
            @(posedge clk); #1;
            if (peak_valid || busy || peak_count != 0) pvSeen++;
        end
        in_valid = 1'b0;
        checkOutput("idle_no_activity", pvSeen, 0);

        // Basic peak
        doStart(16'd100, 16'd20);
        checkOutput("start_busy", {31'd0, busy}, 1);
        checkOutput("start_count", {24'd0, peak_count}, 0);
        vec = '{16'd0, 16'd50, 16'd120, 16'd200, 16'd185, 16'd170};
        applyStimulus();
        checkOutput("basic_pv_pattern", pvBits, 32'b100000);
        checkOutput("basic_value", {16'd0, peak_value}, 200);
        checkOutput("basic_index", {16'd0, peak_index}, 3);
        checkOutput("basic_count", {24'd0, peak_count}, 1);
        @(posedge clk); #1;
        checkOutput("basic_pv_one_cycle", {31'd0, peak_valid}, 0);

        // Tie keeps earlier index
        doStart(16'd100, 16'd20);
        vec = '{16'd150, 16'd200, 16'd200, 16'd170};
        applyStimulus();
        checkOutput("tie_pv_pattern", pvBits, 32'b1000);
        checkOutput("tie_value", {16'd0, peak_value}, 200);
        checkOutput("tie_index", {16'd0, peak_index}, 1);
        checkOutput("tie_count", {24'd0, peak_count}, 1);

        // Second peak too close (6-3 < 8): suppressed
        doStart(16'd100, 16'd20);
        vec = '{16'd0, 16'd50, 16'd120, 16'd200, 16'd160, 16'd190, 16'd250, 16'd210};
        applyStimulus();
        checkOutput("close_pv_pattern", pvBits, 32'b00010000);
        checkOutput("close_value", {16'd0, peak_value}, 200);
        checkOutput("close_index", {16'd0, peak_index}, 3);
        checkOutput("close_count", {24'd0, peak_count}, 1);

        // Second peak exactly MIN_DIST away (11-3 = 8): reported
        doStart(16'd100, 16'd20);
        vec = '{16'd0, 16'd50, 16'd120, 16'd200, 16'd160, 16'd160, 16'd160, 16'd160,
                16'd160, 16'd160, 16'd190, 16'd250, 16'd210};
        applyStimulus();
        checkOutput("far_pv_pattern", pvBits, 32'b1000000010000);
        checkOutput("far_value", {16'd0, peak_value}, 250);
        checkOutput("far_index", {16'd0, peak_index}, 11);
        checkOutput("far_count", {24'd0, peak_count}, 2);

        // Full-scale swing must not wrap
        doStart(16'h8000, 16'd100);
        vec = '{16'h7FFF, 16'h8000};
        applyStimulus();
        checkOutput("extreme_pv_pattern", pvBits, 32'b10);
        checkOutput("extreme_value", {16'd0, peak_value}, 32'h7FFF);
        checkOutput("extreme_index", {16'd0, peak_index}, 0);
        checkOutput("extreme_count", {24'd0, peak_count}, 1);

        // Restart mid-TRACK with a same-cycle confirming sample
        doStart(16'd100, 16'd20);
        vec = '{16'd150, 16'd200};
        applyStimulus();
        in_valid = 1'b1;
        data_in  = 16'd170;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("restart_pv", {31'd0, peak_valid}, 0);
        checkOutput("restart_busy", {31'd0, busy}, 1);
        checkOutput("restart_count", {24'd0, peak_count}, 0);
        vec = '{16'd120, 16'd150, 16'd100};
        applyStimulus();
        checkOutput("restart_pv_pattern", pvBits, 32'b100);
        checkOutput("restart_value", {16'd0, peak_value}, 150);
        checkOutput("restart_index", {16'd0, peak_index}, 1);
        checkOutput("restart_new_count", {24'd0, peak_count}, 1);

        // Reset together with the confirming sample drops the report
        doStart(16'd100, 16'd20);
        vec = '{16'd150, 16'd200};
        applyStimulus();
        in_valid = 1'b1;
        data_in  = 16'd170;
        rst      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        checkOutput("rst_pv", {31'd0, peak_valid}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_count", {24'd0, peak_count}, 0);
        checkOutput("rst_value", {16'd0, peak_value}, 0);
        @(posedge clk); #1;
        checkOutput("rst_pv_later", {31'd0, peak_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
